// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared constants for the register-file writeback scheduler.
// The package holds register indices, arbitration modes and grant encodings.
package regfile_wb_scheduler_pkg;

    localparam int REG0     = 0;
    localparam int T_IDX    = 15;

    localparam int PRIO_RR  = 0;
    localparam int PRIO_MEM = 1;

    typedef enum logic {
        GNT_ALU = 1'b0,
        GNT_MEM = 1'b1
    } grant_e;

endpackage

// File: rtl/regfile_wb_scheduler_wb_scoreboard.sv
// Per-register pending-write counters used for decode read-after-write stalls.
// The module also provides issue back-pressure and a sticky underflow error.
module wb_scoreboard
    import regfile_wb_scheduler_pkg::*;
#(
    parameter int AW    = 4,
    parameter int CNT_W = 2
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_reg,
    input  logic          commit_valid,
    input  logic [AW-1:0] commit_reg,
    input  logic [AW-1:0] Rs,
    input  logic [AW-1:0] Rt,
    output logic          issue_ready,
    output logic          rs_busy,
    output logic          rt_busy,
    output logic          wb_err
);

    localparam int NREG = 2**AW;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NREG-1:0][CNT_W-1:0] cnt;

    // A commit to the same register frees a slot in the same cycle.
    assign issue_ready = (issue_reg == AW'(REG0)) || (cnt[issue_reg] != CNT_MAX)
                       || (commit_valid && (commit_reg == issue_reg));

    assign cnt[REG0] = '0;

    for (genvar gi = 1; gi < NREG; gi++) begin : g_cnt
        logic             inc;
        logic             dec;
        logic [CNT_W-1:0] cnt_reg;

        assign inc = issue_valid && issue_ready && (issue_reg == AW'(gi));
        assign dec = commit_valid && (commit_reg == AW'(gi));

        always_ff @(posedge Clk or posedge Rst) begin
            if (Rst) begin
                cnt_reg <= '0;
            end else if (inc && !dec) begin
                cnt_reg <= cnt_reg + 1'b1;
            end else if (dec && !inc && (cnt_reg != '0)) begin
                cnt_reg <= cnt_reg - 1'b1;
            end
        end

        assign cnt[gi] = cnt_reg;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wb_err <= 1'b0;
        end else if (commit_valid && (commit_reg != AW'(REG0)) && (cnt[commit_reg] == '0)) begin
            wb_err <= 1'b1;
        end
    end

    assign rs_busy = (Rs != AW'(REG0)) && (cnt[Rs] != '0);
    assign rt_busy = (Rt != AW'(REG0)) && (cnt[Rt] != '0);

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Arbitrates the single register-file write port between ALU and MEM writeback.
// Writes are registered one cycle after the handshake.
module regfile_wb_scheduler
    import regfile_wb_scheduler_pkg::*;
#(
    parameter int DW        = 16,
    parameter int AW        = 4,
    parameter int PRIO_MODE = 0,
    parameter int CNT_W     = 2
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_reg,
    input  logic [DW-1:0] alu_data,
    output logic          alu_ready,
    input  logic          mem_valid,
    input  logic [AW-1:0] mem_reg,
    input  logic [DW-1:0] mem_data,
    output logic          mem_ready,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_reg,
    output logic          issue_ready,
    input  logic [AW-1:0] Rs,
    input  logic [AW-1:0] Rt,
    output logic          rs_busy,
    output logic          rt_busy,
    output logic          RegWre,
    output logic [AW-1:0] WriteReg,
    output logic [DW-1:0] WriteData,
    output logic          wb_err
);

    grant_e        last_grant;
    logic          grant_alu;
    logic          grant_mem;
    logic          handshake;
    logic [AW-1:0] sel_reg;
    logic [DW-1:0] sel_data;

    // ALU wins a tie only in round-robin mode and only when MEM was last served.
    always_comb begin
        grant_alu = alu_valid && (!mem_valid
                    || ((PRIO_MODE == PRIO_RR) && (last_grant == GNT_MEM)));
        grant_mem = mem_valid && !grant_alu;
    end

    assign alu_ready = grant_alu;
    assign mem_ready = grant_mem;
    assign handshake = grant_alu || grant_mem;
    assign sel_reg   = grant_alu ? alu_reg  : mem_reg;
    assign sel_data  = grant_alu ? alu_data : mem_data;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            last_grant <= GNT_MEM;
            RegWre     <= 1'b0;
            WriteReg   <= '0;
            WriteData  <= '0;
        end else begin
            RegWre <= handshake && (sel_reg != AW'(REG0));
            if (handshake) begin
                last_grant <= grant_mem ? GNT_MEM : GNT_ALU;
            end
            // REG0 writes are swallowed: they count as a grant but never reach the file.
            if (handshake && (sel_reg != AW'(REG0))) begin
                WriteReg  <= sel_reg;
                WriteData <= sel_data;
            end
        end
    end

    wb_scoreboard #(
        .AW    (AW),
        .CNT_W (CNT_W)
    ) u_scoreboard (
        .Clk          (Clk),
        .Rst          (Rst),
        .issue_valid  (issue_valid),
        .issue_reg    (issue_reg),
        .commit_valid (handshake),
        .commit_reg   (sel_reg),
        .Rs           (Rs),
        .Rt           (Rt),
        .issue_ready  (issue_ready),
        .rs_busy      (rs_busy),
        .rt_busy      (rt_busy),
        .wb_err       (wb_err)
    );

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Schedules the single register-file write port between two writeback requesters: ALU result (ALU) and memory load return (MEM).
- Keeps a per-register pending-write scoreboard so decode can stall on read-after-write hazards.
- Sits between the execute/memory stages and the 16x16 register file.
- Drives the register file's RegWre, WriteReg and WriteData. The register file itself handles the T-flag conversion.

Parameters:
- DW, 16, data width.
- AW, 4, register address width; register count NREG = 2**AW.
- PRIO_MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority with MEM first.
- CNT_W, 2, width of each per-register pending counter; saturates at 2**CNT_W-1.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Rst  in  1  asynchronous, active-high reset.
- alu_valid  in  1  ALU writeback request.
- alu_reg  in  AW  ALU destination register.
- alu_data  in  DW  ALU result.
- alu_ready  out  1  ALU request accepted this cycle.
- mem_valid  in  1  MEM writeback request.
- mem_reg  in  AW  MEM destination register.
- mem_data  in  DW  load data.
- mem_ready  out  1  MEM request accepted this cycle.
- issue_valid  in  1  decode issues an instruction with a destination register.
- issue_reg  in  AW  destination of the issued instruction.
- issue_ready  out  1  scoreboard can accept the issue.
- Rs  in  AW  decode read-port-1 address.
- Rt  in  AW  decode read-port-2 address.
- rs_busy  out  1  Rs has a pending write.
- rt_busy  out  1  Rt has a pending write.
- RegWre  out  1  register-file write enable (registered).
- WriteReg  out  AW  register-file write address (registered).
- WriteData  out  DW  register-file write data (registered).
- wb_err  out  1  sticky error flag: a commit arrived for a register whose counter was 0.

Behaviour:
- Reset: asserting Rst clears, asynchronously:
  - all pending counters;
  - last_grant (set to MEM, so ALU wins the first round-robin tie);
  - RegWre, WriteReg and WriteData to 0;
  - wb_err to 0.
  - Reset mid-operation discards any pending grant. No write is issued during the cycle after Rst deasserts unless a new request arrives.
- Arbitration is combinational from valids:
  - Only one valid: that requester is granted.
  - Both valid, PRIO_MODE=0: grant the requester that was not last granted. last_grant updates only on a real grant.
  - Both valid, PRIO_MODE=1: MEM always wins. ALU may starve, which is accepted.
  - The ready of the granted requester is high in the same cycle. A handshake is valid&&ready.
  - Requesters hold valid, reg and data stable until ready.
- Write port:
  - On a handshake, the next posedge loads RegWre=1, WriteReg=reg, WriteData=data.
  - With no handshake, RegWre=0 and WriteReg/WriteData hold their values.
  - Latency is 1 cycle from handshake to RegWre. The register file commits on the following negedge.
- REG0 writes:
  - A handshake with reg==0 is accepted and counts as a grant.
  - RegWre stays 0 for it, and the scoreboard is untouched.
- Scoreboard, per-register counter cnt[r]:
  - Issue with issue_reg != 0 and issue_ready: cnt+1. issue_reg==0 is ignored, and issue_ready is always 1 for it.
  - issue_ready = (cnt[issue_reg] != max) || (a commit to issue_reg happens this cycle).
  - Commit = handshake with reg r != 0: cnt-1.
  - Issue and commit to the same register in the same cycle: cnt unchanged.
  - Commit when cnt[r]==0: cnt stays 0 and wb_err sets. wb_err clears only on Rst.
  - rs_busy = (Rs!=0) && (cnt[Rs]!=0). rt_busy is the same form on Rt.
  - Busy reflects registered counters only. There is no bypass of same-cycle commits.
- Simultaneous ALU and MEM writes to the same register: both are serialized in grant order. The last write wins, and both decrement.

Decomposition:
- Shared package/include:
  - REG0 index (0) and T index constants;
  - PRIO_RR / PRIO_MEM encodings;
  - grant encoding GNT_ALU = 0, GNT_MEM = 1.
- One sub-module, wb_scoreboard: holds the counter array, issue_ready, busy lookups and wb_err.
- The arbiter and write-port register stay in the top module.

Test Plan:
- Reset, then ALU only with alu_reg=3, alu_data=0x1234 → alu_ready=1 in the same cycle; next cycle RegWre=1, WriteReg=3, WriteData=0x1234; the cycle after, RegWre=0.
- PRIO_MODE=0, both valid for 4 cycles, ALU reg 1 / MEM reg 2 → grants alternate ALU, MEM, ALU, MEM; WriteReg sequence is 1, 2, 1, 2.
- PRIO_MODE=1, both valid for 3 cycles → mem_ready=1 and alu_ready=0 every cycle; WriteReg=MEM reg every cycle.
- Issue reg 5 three times → cnt=3, issue_ready=0 for reg 5, and rs_busy=1 with Rs=5. One commit to 5 → issue_ready=1. Three commits → rs_busy=0.
- Issue reg 7 and ALU commit to reg 7 in the same cycle with cnt=1 → cnt stays 1 and rt_busy stays 1 with Rt=7. ALU commit to reg 9 with cnt=0 → wb_err=1, and it stays 1.
- ALU write to reg 0 with data 0xFFFF → alu_ready=1, RegWre stays 0, counters unchanged. Assert Rst mid-stream with cnt[4]=2 → counters 0, RegWre=0 and wb_err=0 immediately.
